// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the half-precision multiply wrapper.
// Keeps the credit arithmetic in one place so the top and any checker agree on it.
package fp_mul_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam fp16_t FP16_ONE = 16'h3C00;
    localparam fp16_t FP16_TWO = 16'h4000;

    // A slot is free while buffered plus outstanding results leave room in the FIFO.
    function automatic logic has_credit(
        input int unsigned depth,
        input int unsigned used_count,
        input int unsigned used_inflight
    );
        return (used_count + used_inflight) < depth;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: the head entry is visible on
// head whenever empty is low, and pop simply advances past it.
module sync_fifo_fwft #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    // A pop frees the slot this cycle, so a push at full is accepted alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_mul_result_buffer.sv
// Issue controller and result buffer around a multiply core that cannot be stalled:
// operands are issued only against a reserved FIFO slot, so no result is ever dropped.
module fp_mul_result_buffer
    import fp_mul_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 16,
    parameter int MUL_LATENCY = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_op_tvalid,
    output logic                       s_op_tready,
    input  logic [DATA_W-1:0]          s_op_a_tdata,
    input  logic [DATA_W-1:0]          s_op_b_tdata,
    output logic                       mul_a_tvalid,
    output logic [DATA_W-1:0]          mul_a_tdata,
    output logic                       mul_b_tvalid,
    output logic [DATA_W-1:0]          mul_b_tdata,
    input  logic                       mul_result_tvalid,
    input  logic [DATA_W-1:0]          mul_result_tdata,
    output logic                       m_result_tvalid,
    input  logic                       m_result_tready,
    output logic [DATA_W-1:0]          m_result_tdata,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic                       overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int FL_W  = $clog2(MUL_LATENCY + 2);

    state_t            state;
    logic [FL_W-1:0]   flush_cnt;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              running;
    logic              issue;
    logic              ret;
    logic              pop;
    logic              issue_valid;

    assign running = (state == RUN);

    // Ready depends only on registered state so it never combinationally follows tvalid.
    assign s_op_tready = running && has_credit(32'(DEPTH), 32'(count), 32'(inflight));

    assign issue = s_op_tvalid && s_op_tready;
    assign ret   = running && mul_result_tvalid;
    assign pop   = m_result_tvalid && m_result_tready;

    assign m_result_tvalid = !fifo_empty;
    assign mul_a_tvalid    = issue_valid;
    assign mul_b_tvalid    = issue_valid;

    // FLUSH waits out one full core latency so results launched before reset are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FLUSH;
            flush_cnt <= FL_W'(MUL_LATENCY);
        end else begin
            case (state)
                FLUSH: begin
                    if (flush_cnt <= FL_W'(1)) begin
                        state <= RUN;
                    end
                    if (flush_cnt != '0) begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state     <= FLUSH;
                    flush_cnt <= FL_W'(MUL_LATENCY);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid <= 1'b0;
            mul_a_tdata <= '0;
            mul_b_tdata <= '0;
        end else begin
            issue_valid <= issue;
            if (issue) begin
                mul_a_tdata <= s_op_a_tdata;
                mul_b_tdata <= s_op_b_tdata;
            end
        end
    end

    // A return with nothing outstanding can only come from a misbehaving core; hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({issue, ret})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= (inflight != '0) ? inflight - 1'b1 : inflight;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ret && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ret),
        .push_data (mul_result_tdata),
        .pop       (pop),
        .head      (m_result_tdata),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Directed bench for fp_mul_result_buffer with a behavioural fixed-latency fp16 core
// and an expected-result queue filled on issue and drained on each output beat.
module tb_fp_mul_result_buffer;
    import fp_mul_pkg::*;

    localparam int DATA_W      = 16;
    localparam int DEPTH       = 16;
    localparam int MUL_LATENCY = 8;
    localparam int CNT_W       = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              s_op_tvalid = 1'b0;
    logic              s_op_tready;
    logic [DATA_W-1:0] s_op_a_tdata = '0;
    logic [DATA_W-1:0] s_op_b_tdata = '0;
    logic              mul_a_tvalid;
    logic [DATA_W-1:0] mul_a_tdata;
    logic              mul_b_tvalid;
    logic [DATA_W-1:0] mul_b_tdata;
    logic              mul_result_tvalid;
    logic [DATA_W-1:0] mul_result_tdata;
    logic              m_result_tvalid;
    logic              m_result_tready = 1'b0;
    logic [DATA_W-1:0] m_result_tdata;
    logic [CNT_W-1:0]  inflight;
    logic              overflow;

    logic [DATA_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_issue = 0;
    int n_pop   = 0;
    int waited, snap_i, snap_p, k;

    always #5 clk = ~clk;

    fp_mul_result_buffer #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .MUL_LATENCY (MUL_LATENCY)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .s_op_tvalid       (s_op_tvalid),
        .s_op_tready       (s_op_tready),
        .s_op_a_tdata      (s_op_a_tdata),
        .s_op_b_tdata      (s_op_b_tdata),
        .mul_a_tvalid      (mul_a_tvalid),
        .mul_a_tdata       (mul_a_tdata),
        .mul_b_tvalid      (mul_b_tvalid),
        .mul_b_tdata       (mul_b_tdata),
        .mul_result_tvalid (mul_result_tvalid),
        .mul_result_tdata  (mul_result_tdata),
        .m_result_tvalid   (m_result_tvalid),
        .m_result_tready   (m_result_tready),
        .m_result_tdata    (m_result_tdata),
        .inflight          (inflight),
        .overflow          (overflow)
    );

    // Half-precision multiply for normal operands with normal results, round to nearest even.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [21:0] p;
        logic [10:0] m;
        logic        g, st;
        logic [11:0] rm;
        logic [9:0]  mant;
        s = a[15] ^ b[15];
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        if (p[21]) begin
            m  = p[21:11];
            g  = p[10];
            st = |p[9:0];
            e  = e + 1;
        end else begin
            m  = p[20:10];
            g  = p[9];
            st = |p[8:0];
        end
        rm = {1'b0, m} + ((g && (st || m[0])) ? 12'd1 : 12'd0);
        if (rm[11]) begin
            e    = e + 1;
            mant = 10'd0;
        end else begin
            mant = rm[9:0];
        end
        return {s, e[4:0], mant};
    endfunction

    function automatic logic [15:0] rand_norm();
        return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom_range(0, 1023))};
    endfunction

    // Core model: never reset, fixed latency, plus an injection path for forcing results.
    logic [MUL_LATENCY-1:0] core_v = '0;
    logic [DATA_W-1:0]      core_d [MUL_LATENCY];
    logic                   inj_v = 1'b0;
    logic [DATA_W-1:0]      inj_d = '0;

    always @(posedge clk) begin
        core_v    <= {core_v[MUL_LATENCY-2:0], mul_a_tvalid && mul_b_tvalid};
        core_d[0] <= fp16_mul(mul_a_tdata, mul_b_tdata);
        for (int i = 1; i < MUL_LATENCY; i++) begin
            core_d[i] <= core_d[i-1];
        end
    end

    assign mul_result_tvalid = core_v[MUL_LATENCY-1] | inj_v;
    assign mul_result_tdata  = inj_v ? inj_d : core_d[MUL_LATENCY-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes are judged at the falling edge; inputs change just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!reset && s_op_tvalid && s_op_tready) begin
            exp_q.push_back(fp16_mul(s_op_a_tdata, s_op_b_tdata));
            n_issue++;
        end
        if (!reset && m_result_tvalid && m_result_tready) begin
            n_pop++;
            check("result_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("result_data", 32'(m_result_tdata), 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int w);
        w = 0;
        while (!m_result_tvalid && w < budget) begin
            tick();
            w++;
        end
    endtask

    initial begin
        // Reset and flush window
        repeat (3) tick();
        check("rst_tready", 32'(s_op_tready), 0);
        check("rst_m_valid", 32'(m_result_tvalid), 0);
        check("rst_m_data", 32'(m_result_tdata), 0);
        check("rst_mul_valid", 32'({mul_a_tvalid, mul_b_tvalid}), 0);
        check("rst_mul_data", 32'({mul_a_tdata, mul_b_tdata}), 0);
        check("rst_inflight", 32'(inflight), 0);
        check("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            check("flush_tready", 32'(s_op_tready), 0);
            check("flush_outputs", 32'({m_result_tvalid, mul_a_tvalid, overflow, inflight}), 0);
            tick();
        end
        check("run_tready", 32'(s_op_tready), 1);

        // Single operation
        m_result_tready = 1'b1;
        s_op_tvalid = 1'b1;
        s_op_a_tdata = 16'hb600;
        s_op_b_tdata = 16'h7451;
        tick();
        s_op_tvalid = 1'b0;
        s_op_a_tdata = '0;
        s_op_b_tdata = '0;
        check("issue_valid", 32'({mul_a_tvalid, mul_b_tvalid}), 32'b11);
        check("issue_a", 32'(mul_a_tdata), 32'h0000b600);
        check("issue_b", 32'(mul_b_tdata), 32'h00007451);
        check("issue_inflight", 32'(inflight), 1);
        tick();
        check("issue_valid_drop", 32'({mul_a_tvalid, mul_b_tvalid}), 0);
        check("issue_a_held", 32'(mul_a_tdata), 32'h0000b600);
        wait_valid(4 * MUL_LATENCY, waited);
        check("single_timeout", 32'(m_result_tvalid), 1);
        check("single_data", 32'(m_result_tdata), 32'h0000EE7A);
        tick();
        check("single_m_valid_after", 32'(m_result_tvalid), 0);
        check("single_inflight", 32'(inflight), 0);
        check("single_queue", 32'(exp_q.size()), 0);

        // Fill: ready low downstream, operands offered continuously
        m_result_tready = 1'b0;
        s_op_tvalid = 1'b1;
        s_op_a_tdata = FP16_ONE;
        s_op_b_tdata = FP16_TWO;
        n_issue = 0;
        for (int i = 0; i < 20; i++) tick();
        check("fill_accepted", 32'(n_issue), 32'(DEPTH));
        repeat (MUL_LATENCY + 2) tick();
        check("fill_no_more", 32'(n_issue), 32'(DEPTH));
        check("fill_tready", 32'(s_op_tready), 0);
        check("fill_m_valid", 32'(m_result_tvalid), 1);
        check("fill_head", 32'(m_result_tdata), 32'h00004000);
        check("fill_inflight", 32'(inflight), 0);
        check("fill_overflow", 32'(overflow), 0);
        check("fill_queue", 32'(exp_q.size()), 32'(DEPTH));

        // Drain from full with operands still offered
        m_result_tready = 1'b1;
        n_issue = 0;
        n_pop = 0;
        tick();
        check("drain_first_pop", 32'(n_pop), 1);
        check("drain_first_issue", 32'(n_issue), 0);
        check("drain_credit_back", 32'(s_op_tready), 1);
        s_op_a_tdata = rand_norm();
        s_op_b_tdata = rand_norm();
        tick();
        check("drain_one_issue", 32'(n_issue), 1);
        for (int i = 0; i < 42; i++) begin
            s_op_a_tdata = rand_norm();
            s_op_b_tdata = rand_norm();
            tick();
        end
        snap_i = n_issue;
        snap_p = n_pop;
        for (int i = 0; i < 16; i++) begin
            s_op_a_tdata = rand_norm();
            s_op_b_tdata = rand_norm();
            tick();
        end
        check("steady_issue", 32'(n_issue - snap_i), 16);
        check("steady_pop", 32'(n_pop - snap_p), 16);
        s_op_tvalid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            tick();
            k++;
        end
        check("drain_queue", 32'(exp_q.size()), 0);
        check("drain_m_valid", 32'(m_result_tvalid), 0);
        check("drain_inflight", 32'(inflight), 0);
        check("drain_overflow", 32'(overflow), 0);

        // Reset with operations in flight
        snap_i = n_issue;
        s_op_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_op_a_tdata = rand_norm();
            s_op_b_tdata = rand_norm();
            tick();
        end
        s_op_tvalid = 1'b0;
        repeat (2) tick();
        check("mid_issued", 32'(n_issue - snap_i), 5);
        check("mid_inflight", 32'(inflight), 5);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            check("reflush_m_valid", 32'(m_result_tvalid), 0);
            check("reflush_tready", 32'(s_op_tready), 0);
            tick();
        end
        check("reflush_inflight", 32'(inflight), 0);
        check("reflush_empty", 32'(m_result_tvalid), 0);
        check("reflush_tready_run", 32'(s_op_tready), 1);
        s_op_tvalid = 1'b1;
        s_op_a_tdata = FP16_ONE;
        s_op_b_tdata = FP16_ONE;
        tick();
        s_op_tvalid = 1'b0;
        wait_valid(4 * MUL_LATENCY, waited);
        check("one_timeout", 32'(m_result_tvalid), 1);
        check("one_data", 32'(m_result_tdata), 32'h00003C00);
        snap_p = n_pop;
        repeat (15) tick();
        check("one_single_beat", 32'(n_pop - snap_p), 1);
        check("one_queue", 32'(exp_q.size()), 0);

        // Forced results into a stalled FIFO
        m_result_tready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            inj_v = 1'b1;
            inj_d = 16'(16'h1000 + i);
            if (i < DEPTH) exp_q.push_back(inj_d);
            tick();
            if (i == DEPTH - 1) check("ovf_before", 32'(overflow), 0);
        end
        inj_v = 1'b0;
        check("ovf_set", 32'(overflow), 1);
        check("ovf_head", 32'(m_result_tdata), 32'h00001000);
        check("ovf_tready", 32'(s_op_tready), 0);
        repeat (3) tick();
        check("ovf_sticky", 32'(overflow), 1);
        m_result_tready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        check("ovf_drain_queue", 32'(exp_q.size()), 0);
        check("ovf_dropped_17th", 32'(m_result_tvalid), 0);
        check("ovf_sticky_after_drain", 32'(overflow), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
